// File: rtl/axis_traffic_gen_pkg.sv
// Shared types and helpers for the AXI-Stream traffic generator.
// Holds the FSM state encoding, destination mode codes and the round-robin step function.
package axis_traffic_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } tg_state_e;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Next endpoint after cur, wrapping at n and never landing on self_addr.
    // A single-endpoint network can only address itself.
    function automatic int unsigned next_rr_dest(input int unsigned cur,
                                                 input int unsigned self_addr,
                                                 input int unsigned n);
        int unsigned nxt;
        if (n <= 32'd1) begin
            nxt = self_addr;
        end else begin
            nxt = (cur + 32'd1) % n;
            if (nxt == self_addr) begin
                nxt = (nxt + 32'd1) % n;
            end else begin
                nxt = nxt;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/axis_traffic_gen_if.sv
// AXI-Stream beat bundle between the traffic generator and the router injection port.
interface axis_traffic_gen_if #(
    parameter int TDATA_WIDTH = 32,
    parameter int TID_WIDTH   = 2,
    parameter int TDEST_WIDTH = 2
) ();
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tlast;
    logic [TID_WIDTH-1:0]   tid;
    logic [TDEST_WIDTH-1:0] tdest;

    modport master (output tvalid, output tdata, output tlast, output tid, output tdest,
                    input tready);
    modport slave  (input tvalid, input tdata, input tlast, input tid, input tdest,
                    output tready);
endinterface

// File: rtl/axis_tg_dest_seq.sv
// Destination sequencer: loads the first destination on start and steps round-robin
// (skipping the local endpoint) each time a packet completes.
module axis_tg_dest_seq
    import axis_traffic_gen_pkg::*;
#(
    parameter int TDEST_WIDTH       = 2,
    parameter int NOC_NUM_ENDPOINTS = 4
) (
    input  logic                   clk_usr,
    input  logic                   rst_usr,
    input  logic                   load,
    input  logic                   advance,
    input  logic                   mode,
    input  logic [TDEST_WIDTH-1:0] fixed_dest,
    input  logic [TDEST_WIDTH-1:0] self_addr,
    output logic [TDEST_WIDTH-1:0] dest
);

    logic                   mode_r;
    logic [TDEST_WIDTH-1:0] self_r;
    logic [TDEST_WIDTH-1:0] dest_r;
    logic [TDEST_WIDTH-1:0] first_s;
    logic [TDEST_WIDTH-1:0] next_s;

    assign first_s = TDEST_WIDTH'(next_rr_dest(32'(self_addr), 32'(self_addr), 32'(NOC_NUM_ENDPOINTS)));
    assign next_s  = TDEST_WIDTH'(next_rr_dest(32'(dest_r), 32'(self_r), 32'(NOC_NUM_ENDPOINTS)));

    // Destination register: configuration latched on load, stepped only between packets.
    always_ff @(posedge clk_usr) begin
        if (rst_usr) begin
            mode_r <= MODE_FIXED;
            self_r <= {TDEST_WIDTH{1'b0}};
            dest_r <= {TDEST_WIDTH{1'b0}};
        end else if (load) begin
            mode_r <= mode;
            self_r <= self_addr;
            dest_r <= (mode == MODE_RR) ? first_s : fixed_dest;
        end else if (advance && (mode_r == MODE_RR)) begin
            dest_r <= next_s;
        end else begin
            dest_r <= dest_r;
        end
    end

    assign dest = dest_r;

endmodule

// File: rtl/axis_traffic_gen.sv
// Deterministic AXI-Stream packet source with packet/stall statistics.
// Each beat carries {packet sequence, beat index} so the sink can self-check ordering.
module axis_traffic_gen
    import axis_traffic_gen_pkg::*;
#(
    parameter int TDATA_WIDTH       = 32,
    parameter int TID_WIDTH         = 2,
    parameter int TDEST_WIDTH       = 2,
    parameter int NOC_NUM_ENDPOINTS = 4,
    parameter int MAX_PKT_LEN       = 16,
    parameter int LEN_WIDTH         = $clog2(MAX_PKT_LEN + 1)
) (
    input  logic                   clk_usr,
    input  logic                   rst_usr,
    input  logic                   start,
    input  logic                   stop,
    input  logic [15:0]            cfg_num_pkts,
    input  logic [LEN_WIDTH-1:0]   cfg_pkt_len,
    input  logic                   cfg_mode,
    input  logic [TDEST_WIDTH-1:0] cfg_fixed_dest,
    input  logic [TDEST_WIDTH-1:0] cfg_self_addr,
    input  logic [TID_WIDTH-1:0]   cfg_tid,
    axis_traffic_gen_if.master     axis_out,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            pkt_count,
    output logic [31:0]            stall_cycles
);

    localparam int HALF_W = TDATA_WIDTH / 2;

    tg_state_e              state_r;
    logic [LEN_WIDTH-1:0]   len_eff_r;
    logic [15:0]            num_pkts_r;
    logic [TID_WIDTH-1:0]   tid_r;
    logic [LEN_WIDTH-1:0]   beat_r;
    logic [HALF_W-1:0]      seq_r;
    logic                   stop_pend_r;
    logic                   tvalid_r;
    logic                   tlast_r;
    logic [TDATA_WIDTH-1:0] tdata_r;
    logic                   busy_r;
    logic                   done_r;
    logic [31:0]            pkt_count_r;
    logic [31:0]            stall_r;

    logic [LEN_WIDTH-1:0]   len_eff_s;
    logic [LEN_WIDTH-1:0]   beat_nxt_s;
    logic [HALF_W-1:0]      seq_nxt_s;
    logic [31:0]            pkt_count_nxt_s;
    logic                   hs_s;
    logic                   launch_s;
    logic                   last_hs_s;
    logic                   finish_s;
    logic                   advance_s;
    logic [TDEST_WIDTH-1:0] dest_s;

    // Length clamping and the handshake/termination decode for the current cycle.
    always_comb begin
        if (cfg_pkt_len == {LEN_WIDTH{1'b0}}) begin
            len_eff_s = LEN_WIDTH'(32'd1);
        end else if (cfg_pkt_len > LEN_WIDTH'(MAX_PKT_LEN)) begin
            len_eff_s = LEN_WIDTH'(MAX_PKT_LEN);
        end else begin
            len_eff_s = cfg_pkt_len;
        end
        beat_nxt_s      = beat_r + LEN_WIDTH'(32'd1);
        seq_nxt_s       = seq_r + HALF_W'(32'd1);
        pkt_count_nxt_s = pkt_count_r + 32'd1;
        hs_s            = tvalid_r && axis_out.tready;
        launch_s        = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        last_hs_s       = (state_r == ST_SEND) && hs_s && tlast_r;
        // A stop arriving with the final beat still ends the run after that packet.
        finish_s        = last_hs_s &&
                          (((num_pkts_r != 16'd0) && (pkt_count_nxt_s == {16'd0, num_pkts_r})) ||
                           stop_pend_r || stop);
        advance_s       = last_hs_s && !finish_s;
    end

    // Main FSM; every stream and status output is driven straight from a register.
    always_ff @(posedge clk_usr) begin
        if (rst_usr) begin
            state_r     <= ST_IDLE;
            len_eff_r   <= {LEN_WIDTH{1'b0}};
            num_pkts_r  <= 16'd0;
            tid_r       <= {TID_WIDTH{1'b0}};
            beat_r      <= {LEN_WIDTH{1'b0}};
            seq_r       <= {HALF_W{1'b0}};
            stop_pend_r <= 1'b0;
            tvalid_r    <= 1'b0;
            tlast_r     <= 1'b0;
            tdata_r     <= {TDATA_WIDTH{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pkt_count_r <= 32'd0;
            stall_r     <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (launch_s) begin
                        state_r     <= ST_SEND;
                        busy_r      <= 1'b1;
                        done_r      <= 1'b0;
                        len_eff_r   <= len_eff_s;
                        num_pkts_r  <= cfg_num_pkts;
                        tid_r       <= cfg_tid;
                        pkt_count_r <= 32'd0;
                        stall_r     <= 32'd0;
                        seq_r       <= {HALF_W{1'b0}};
                        beat_r      <= {LEN_WIDTH{1'b0}};
                        stop_pend_r <= 1'b0;
                        tvalid_r    <= 1'b1;
                        tlast_r     <= (len_eff_s == LEN_WIDTH'(32'd1));
                        tdata_r     <= {TDATA_WIDTH{1'b0}};
                    end
                end
                ST_SEND: begin
                    if (stop) begin
                        stop_pend_r <= 1'b1;
                    end
                    if (tvalid_r && !axis_out.tready && (stall_r != {32{1'b1}})) begin
                        stall_r <= stall_r + 32'd1;
                    end
                    if (hs_s && tlast_r) begin
                        pkt_count_r <= pkt_count_nxt_s;
                        if (finish_s) begin
                            state_r     <= ST_DONE;
                            busy_r      <= 1'b0;
                            done_r      <= 1'b1;
                            tvalid_r    <= 1'b0;
                            tlast_r     <= 1'b0;
                            stop_pend_r <= 1'b0;
                        end else begin
                            seq_r   <= seq_nxt_s;
                            beat_r  <= {LEN_WIDTH{1'b0}};
                            tlast_r <= (len_eff_r == LEN_WIDTH'(32'd1));
                            tdata_r <= {seq_nxt_s, {HALF_W{1'b0}}};
                        end
                    end else if (hs_s) begin
                        beat_r  <= beat_nxt_s;
                        tlast_r <= (beat_nxt_s == (len_eff_r - LEN_WIDTH'(32'd1)));
                        tdata_r <= {seq_r, HALF_W'(beat_nxt_s)};
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b0;
                    tvalid_r <= 1'b0;
                    tlast_r  <= 1'b0;
                end
            endcase
        end
    end

    axis_tg_dest_seq #(
        .TDEST_WIDTH       (TDEST_WIDTH),
        .NOC_NUM_ENDPOINTS (NOC_NUM_ENDPOINTS)
    ) u_dest_seq (
        .clk_usr    (clk_usr),
        .rst_usr    (rst_usr),
        .load       (launch_s),
        .advance    (advance_s),
        .mode       (cfg_mode),
        .fixed_dest (cfg_fixed_dest),
        .self_addr  (cfg_self_addr),
        .dest       (dest_s)
    );

    assign axis_out.tvalid = tvalid_r;
    assign axis_out.tdata  = tdata_r;
    assign axis_out.tlast  = tlast_r;
    assign axis_out.tid    = tid_r;
    assign axis_out.tdest  = dest_s;
    assign busy            = busy_r;
    assign done            = done_r;
    assign pkt_count       = pkt_count_r;
    assign stall_cycles    = stall_r;

endmodule

// File: doc/axis_traffic_gen.md
Name: axis_traffic_gen

Overview:
- AXI-Stream packet source that drives the injection port (axis_in_*) of the router wrapper.
- Used on the user-clock side in parameter-sweep and bring-up builds to generate deterministic, self-checking traffic.
- Emits configurable packets (length, count, fixed or round-robin destination) and keeps throughput/stall statistics.

Parameters:
TDATA_WIDTH, 32, beat width; even, >= 8
TID_WIDTH, 2, tid width
TDEST_WIDTH, 2, destination endpoint width
NOC_NUM_ENDPOINTS, 4, number of endpoints (rows*cols)
MAX_PKT_LEN, 16, maximum beats per packet
LEN_WIDTH, $clog2(MAX_PKT_LEN+1), width of the length fields

Ports:
clk_usr  in  1  user clock (single clock domain)
rst_usr  in  1  synchronous, active-high reset
start  in  1  pulse; latch config and begin (honoured in IDLE/DONE only)
stop  in  1  pulse; finish current packet, then go to DONE
cfg_num_pkts  in  16  packets to send; 0 = unbounded
cfg_pkt_len  in  LEN_WIDTH  beats per packet
cfg_mode  in  1  0 = fixed dest, 1 = round-robin over all endpoints except self
cfg_fixed_dest  in  TDEST_WIDTH  destination when cfg_mode=0
cfg_self_addr  in  TDEST_WIDTH  own endpoint address
cfg_tid  in  TID_WIDTH  tid stamped on every beat
axis_out_tvalid  out  1  to router axis_in_tvalid
axis_out_tready  in  1  from router axis_in_tready
axis_out_tdata  out  TDATA_WIDTH  beat payload
axis_out_tlast  out  1  last beat of packet
axis_out_tid  out  TID_WIDTH  tid
axis_out_tdest  out  TDEST_WIDTH  destination endpoint
busy  out  1  high in SEND
done  out  1  high in DONE
pkt_count  out  32  packets completed (tlast handshakes); wraps
stall_cycles  out  32  cycles with tvalid && !tready; saturates at all-ones

Behaviour:
- Reset: FSM=IDLE. All outputs 0: tvalid, tlast, tdata, tid, tdest, busy, done, pkt_count, stall_cycles. Applies mid-packet: tvalid drops on the next edge and the packet is abandoned.
- States: IDLE, SEND, DONE.
- start in IDLE or DONE:
  - Latch all cfg_*.
  - Clear pkt_count, stall_cycles, seq, beat index.
  - Compute first dest; enter SEND; tvalid=1 in the next cycle (1-cycle latency).
  - start in SEND is ignored.
- Effective length: cfg_pkt_len=0 -> 1; cfg_pkt_len > MAX_PKT_LEN -> MAX_PKT_LEN.
- Beat format: tdata[TDATA_WIDTH-1:TDATA_WIDTH/2] = seq (packet number from 0, truncated). tdata[TDATA_WIDTH/2-1:0] = beat index within packet (from 0).
- Handshake on tvalid && tready.
  - Once tvalid is asserted, tdata/tlast/tid/tdest are held stable until the handshake.
  - tvalid never drops without a handshake except on reset.
  - tlast=1 when beat index = effective length - 1.
- Back-to-back: after a tlast handshake, the next packet's beat 0 is presented in the same cycle it becomes eligible. No bubble; sustained throughput 1 beat/cycle with tready=1.
- Destination:
  - Mode 0: tdest = latched cfg_fixed_dest.
  - Mode 1: first dest = (self+1) mod NOC_NUM_ENDPOINTS; advance by one per completed packet, wrapping at NOC_NUM_ENDPOINTS and skipping self.
  - NOC_NUM_ENDPOINTS=1: dest = self.
  - tdest changes only between packets.
- Termination, on a tlast handshake:
  - pkt_count increments.
  - If cfg_num_pkts != 0 and the new pkt_count = cfg_num_pkts, or a stop is pending: go to DONE, tvalid=0 in the next cycle.
- stop:
  - Sets a pending flag in SEND; the flag clears on leaving SEND.
  - stop in IDLE/DONE is ignored.
  - stop coincident with a tlast handshake terminates after that packet.
- stall_cycles counts in SEND only.
- busy = (state==SEND); done = (state==DONE), held until the next start.

Decomposition:
- Package axis_traffic_gen_pkg: state enum (IDLE/SEND/DONE), mode constants MODE_FIXED/MODE_RR, helper function next_rr_dest(cur, self, n).
- Sub-module axis_tg_dest_seq: round-robin destination sequencer with load/advance inputs, keeping the skip-self logic isolated and separately testable.
- Remainder is one module.

Test Plan:
- Fixed mode, len=4, num=2, dest=2, tid=1, tready=1 -> 8 beats on consecutive cycles starting 1 cycle after start. tdata = 0x0000_0000..0x0000_0003, then 0x0001_0000..0x0001_0003. tlast on beats 3 and 7; tdest=2, tid=1 throughout; done=1, pkt_count=2, stall_cycles=0.
- RR mode, self=1, N=4, len=1, num=5 -> tdest sequence 2,3,0,2,3; no beat ever has tdest=1.
- tready low for 3 cycles mid-packet (len=4) -> tvalid/tdata/tlast held stable throughout; stall_cycles=3; beat order unchanged.
- num=0 (unbounded), stop pulsed during beat 1 of packet 3 (len=4) -> packet 3 completes through tlast, then DONE; pkt_count=4.
- rst_usr asserted mid-packet -> next cycle all outputs 0, state IDLE; a following start restarts with seq=0.
- cfg_pkt_len=0 -> every packet is a single beat with tlast=1. cfg_pkt_len=20 with MAX_PKT_LEN=16 -> 16-beat packets.
